// File: rtl/player_move_ctrl.sv
// Player token sequencer for the dice race board: walks the token tile-by-tile
// along a serpentine path and animates its pixel position once per frame.
module player_move_ctrl #(
   parameter int COLS         = 8,
   parameter int ROWS         = 4,
   parameter int ORIGIN_X     = 40,
   parameter int ORIGIN_Y     = 40,
   parameter int TILE_W       = 64,
   parameter int TILE_H       = 100,
   parameter int SPEED        = 4,
   parameter int DWELL_FRAMES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       move_start,
   input  logic [2:0] dice_val,
   input  logic       restart,
   output logic [9:0] player_x,
   output logic [9:0] player_y,
   output logic [4:0] tile_idx,
   output logic       busy,
   output logic       move_done,
   output logic       at_goal
);

   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] MOVE  = 3'd2;
   localparam logic [2:0] DWELL = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [9:0]    OX         = 10'(ORIGIN_X);
   localparam logic [9:0]    OY         = 10'(ORIGIN_Y);
   localparam logic [9:0]    TW         = 10'(TILE_W);
   localparam logic [9:0]    TH         = 10'(TILE_H);
   localparam logic [9:0]    SPD        = 10'(SPEED);
   localparam logic [4:0]    GOAL       = 5'(COLS*ROWS - 1);
   localparam logic [CW-1:0] COL_END    = CW'(COLS - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

   logic [2:0]    state, state_n;
   logic [2:0]    steps_left, steps_n;
   logic [DW-1:0] dwell_cnt, dwell_n;
   logic [RW-1:0] row, row_n;
   logic [CW-1:0] col, col_n;
   logic          dir, dir_n;   // 0: col increasing, 1: col decreasing
   logic [9:0]    target_x, target_x_n, target_y, target_y_n;
   logic [9:0]    px_n, py_n, step_x, step_y, dist_x, dist_y;
   logic [4:0]    tile_n;
   logic          at_end;

   // One frame of motion toward the target, snapping when closer than SPEED.
   always_comb begin
      dist_x = 10'd0;
      dist_y = 10'd0;
      step_x = player_x;
      step_y = player_y;
      if (target_x >= player_x) begin
         dist_x = target_x - player_x;
         step_x = (dist_x < SPD) ? target_x : player_x + SPD;
      end else begin
         dist_x = player_x - target_x;
         step_x = (dist_x < SPD) ? target_x : player_x - SPD;
      end
      if (target_y >= player_y) begin
         dist_y = target_y - player_y;
         step_y = (dist_y < SPD) ? target_y : player_y + SPD;
      end else begin
         dist_y = player_y - target_y;
         step_y = (dist_y < SPD) ? target_y : player_y - SPD;
      end
   end

   always_comb begin
      state_n    = state;
      steps_n    = steps_left;
      dwell_n    = dwell_cnt;
      row_n      = row;
      col_n      = col;
      dir_n      = dir;
      target_x_n = target_x;
      target_y_n = target_y;
      px_n       = player_x;
      py_n       = player_y;
      tile_n     = tile_idx;
      at_end     = dir ? (col == '0) : (col == COL_END);
      case (state)
         IDLE: begin
            if (restart) begin
               row_n      = '0;
               col_n      = '0;
               dir_n      = 1'b0;
               px_n       = OX;
               py_n       = OY;
               target_x_n = OX;
               target_y_n = OY;
               tile_n     = 5'd0;
            end else if (move_start && dice_val != 3'd0 && dice_val != 3'd7 && !at_goal) begin
               steps_n = dice_val;
               state_n = LOAD;
            end
         end
         LOAD: begin
            // Targets are derived from the current tile, so no multiply is needed.
            if (at_end) begin
               row_n      = row + 1'b1;
               dir_n      = ~dir;
               target_x_n = player_x;
               target_y_n = player_y + TH;
            end else begin
               col_n      = dir ? col - 1'b1 : col + 1'b1;
               target_x_n = dir ? player_x - TW : player_x + TW;
               target_y_n = player_y;
            end
            tile_n  = tile_idx + 5'd1;
            state_n = MOVE;
         end
         MOVE: begin
            if (frame_tick) begin
               px_n = step_x;
               py_n = step_y;
               if (step_x == target_x && step_y == target_y) begin
                  steps_n = steps_left - 3'd1;
                  dwell_n = '0;
                  state_n = DWELL;
               end
            end
         end
         DWELL: begin
            if (frame_tick) begin
               if (dwell_cnt == DWELL_LAST)
                  state_n = (steps_left == 3'd0 || tile_idx == GOAL) ? DONE : LOAD;
               else
                  dwell_n = dwell_cnt + 1'b1;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         steps_left <= 3'd0;
         dwell_cnt  <= '0;
         row        <= '0;
         col        <= '0;
         dir        <= 1'b0;
         target_x   <= OX;
         target_y   <= OY;
         player_x   <= OX;
         player_y   <= OY;
         tile_idx   <= 5'd0;
         busy       <= 1'b0;
         move_done  <= 1'b0;
         at_goal    <= 1'b0;
      end else begin
         state      <= state_n;
         steps_left <= steps_n;
         dwell_cnt  <= dwell_n;
         row        <= row_n;
         col        <= col_n;
         dir        <= dir_n;
         target_x   <= target_x_n;
         target_y   <= target_y_n;
         player_x   <= px_n;
         player_y   <= py_n;
         tile_idx   <= tile_n;
         busy       <= (state_n != IDLE);
         move_done  <= (state_n == DONE);
         at_goal    <= (tile_n == GOAL);
      end
   end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl: final positions of each move are queued
// when the move is requested and compared when move_done pulses.
module tb_player_move_ctrl;

   localparam int COLS = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       move_start = 1'b0;
   logic [2:0] dice_val = 3'd0;
   logic       restart = 1'b0;
   logic [9:0] player_x, player_y;
   logic [4:0] tile_idx;
   logic       busy, move_done, at_goal;

   typedef struct {
      int x;
      int y;
      int tile;
      int goal;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   m_tile = 0;

   player_move_ctrl dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .move_start(move_start),
      .dice_val(dice_val), .restart(restart), .player_x(player_x), .player_y(player_y),
      .tile_idx(tile_idx), .busy(busy), .move_done(move_done), .at_goal(at_goal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t tile_pos(input int t);
      exp_t e;
      int r, c;
      r = t / COLS;
      c = t % COLS;
      if (r % 2 == 1) c = COLS - 1 - c;
      e.x = 40 + c * 64;
      e.y = 40 + r * 100;
      e.tile = t;
      e.goal = (t == 31) ? 1 : 0;
      return e;
   endfunction

   // Scoreboard consumer: each move_done pulse retires one queued move.
   always @(negedge clk) begin
      if (reset && move_done) begin
         exp_t e;
         done_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_move_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("done_x", int'(player_x), e.x);
            chk("done_y", int'(player_y), e.y);
            chk("done_tile", int'(tile_idx), e.tile);
            chk("done_goal", int'(at_goal), e.goal);
         end
      end
   end

   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_move(input int d, input bit expect_move);
      if (expect_move) begin
         m_tile = (m_tile + d > 31) ? 31 : m_tile + d;
         sb.push_back(tile_pos(m_tile));
      end
      @(negedge clk);
      move_start = 1'b1;
      dice_val = 3'(d);
      @(negedge clk) move_start = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_until_done(input string tag);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_done_seen"}, (done_cnt == start + 1) ? 1 : 0, 1);
      @(negedge clk);
      chk({tag, "_busy_after"}, int'(busy), 0);
   endtask

   initial begin
      int d0;
      // Reset values while reset is held
      #12;
      chk("rst_x", int'(player_x), 40);
      chk("rst_y", int'(player_y), 40);
      chk("rst_tile", int'(tile_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(move_done), 0);
      chk("rst_goal", int'(at_goal), 0);
      @(negedge clk) reset = 1'b1;

      // Idle hold under frame ticks
      repeat (100) tick();
      chk("hold_x", int'(player_x), 40);
      chk("hold_y", int'(player_y), 40);
      chk("hold_tile", int'(tile_idx), 0);
      chk("hold_busy", int'(busy), 0);

      // Single step: 4 px per tick, 16 ticks to tile 1
      start_move(1, 1'b1);
      chk("m1_busy", int'(busy), 1);
      chk("m1_tile_load", int'(tile_idx), 1);
      chk("m1_x_pre", int'(player_x), 40);
      tick();
      chk("m1_x_tick1", int'(player_x), 44);
      repeat (15) tick();
      chk("m1_x_tick16", int'(player_x), 104);
      chk("m1_y_tick16", int'(player_y), 40);
      d0 = done_cnt;
      repeat (7) tick();
      chk("m1_no_done_early", done_cnt, d0);
      run_until_done("m1");

      // To tile 6, then 3 steps around the row end
      start_move(5, 1'b1);
      run_until_done("m5");
      d0 = done_cnt;
      start_move(3, 1'b1);
      repeat (16) tick();
      chk("turn_x_t7", int'(player_x), 488);
      repeat (8) tick();
      repeat (24) tick();
      chk("turn_y_mid", int'(player_y), 136);
      chk("turn_x_mid", int'(player_x), 488);
      tick();
      chk("turn_y_t8", int'(player_y), 140);
      chk("turn_tile_t8", int'(tile_idx), 8);
      run_until_done("m3");
      chk("turn_single_done", done_cnt, d0 + 1);
      chk("turn_x_t9", int'(player_x), 424);

      // Requests while busy are ignored
      start_move(6, 1'b1);
      repeat (5) tick();
      @(negedge clk) begin move_start = 1'b1; dice_val = 3'd6; end
      @(negedge clk) begin move_start = 1'b0; restart = 1'b1; end
      @(negedge clk) restart = 1'b0;
      run_until_done("m6_busy");
      chk("busy_ignored_tile", int'(tile_idx), 15);
      start_move(6, 1'b1);
      run_until_done("m6b");
      start_move(6, 1'b1);
      run_until_done("m6c");
      start_move(2, 1'b1);
      run_until_done("m2");

      // Illegal dice values in IDLE
      start_move(0, 1'b0);
      chk("dice0_busy", int'(busy), 0);
      start_move(7, 1'b0);
      chk("dice7_busy", int'(busy), 0);
      chk("dice_bad_tile", int'(tile_idx), 29);

      // Overshoot clamps at the goal
      d0 = done_cnt;
      start_move(6, 1'b1);
      run_until_done("goal");
      chk("goal_single_done", done_cnt, d0 + 1);
      start_move(3, 1'b0);
      chk("goal_ignore_busy", int'(busy), 0);
      chk("goal_ignore_tile", int'(tile_idx), 31);
      tick();
      chk("goal_hold_x", int'(player_x), 40);

      // Restart beats a simultaneous move_start
      @(negedge clk) begin restart = 1'b1; move_start = 1'b1; dice_val = 3'd2; end
      @(negedge clk) begin restart = 1'b0; move_start = 1'b0; end
      @(negedge clk);
      m_tile = 0;
      chk("restart_tile", int'(tile_idx), 0);
      chk("restart_x", int'(player_x), 40);
      chk("restart_y", int'(player_y), 40);
      chk("restart_goal", int'(at_goal), 0);
      chk("restart_busy", int'(busy), 0);

      // Asynchronous reset mid-move
      start_move(2, 1'b1);
      repeat (7) tick();
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst_x", int'(player_x), 40);
      chk("midrst_y", int'(player_y), 40);
      chk("midrst_tile", int'(tile_idx), 0);
      chk("midrst_busy", int'(busy), 0);
      sb.delete();
      m_tile = 0;
      @(negedge clk) reset = 1'b1;
      start_move(1, 1'b1);
      run_until_done("post_rst");
      chk("post_rst_x", int'(player_x), 104);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
